// File: rtl/afifo_pkg.sv
// -----------------------------------------------------------------------------
// afifo_pkg
// Shared definitions for the asynchronous FIFO pointer blocks.
//   - ADDR_WIDTH legality range
//   - bin2gray / gray2bin helpers, sized for the widest legal pointer
//     (callers zero-extend into ptr_max_t and truncate the result)
// -----------------------------------------------------------------------------
package afifo_pkg;

    localparam int unsigned ADDR_WIDTH_MIN = 2;
    localparam int unsigned ADDR_WIDTH_MAX = 10;

    // Pointer is one bit wider than the RAM address.
    localparam int unsigned PTR_MAX_W = ADDR_WIDTH_MAX + 1;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Upper zero bits from zero-extension leave the low bits unaffected.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = '0;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
            b[PTR_MAX_W-1-i] = b[PTR_MAX_W-i] ^ g[PTR_MAX_W-1-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter (XOR prefix chain from MSB).
// Ports:
//   gray_i  [W-1:0]  Gray-coded input
//   bin_o   [W-1:0]  binary equivalent
// -----------------------------------------------------------------------------
module gray2bin #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    always_comb begin
        logic [W-1:0] acc;
        acc        = '0;
        acc[W-1]   = gray_i[W-1];
        for (int unsigned i = 1; i < W; i++) begin
            acc[W-1-i] = acc[W-i] ^ gray_i[W-1-i];
        end
        bin_o = acc;
    end

endmodule

// File: rtl/wptr_full_level.sv
// -----------------------------------------------------------------------------
// wptr_full_level
// Write-domain pointer and status generator for the asynchronous FIFO.
// Ports:
//   wclk         write clock, all state on rising edge
//   rst          asynchronous active-high reset
//   winc         write request this cycle
//   rptr_sync    Gray read pointer, already synchronised into wclk
//   af_margin    almost-full margin (quasi-static)
//   ovf_clr      clears the sticky overflow flag
//   wr_en        RAM write strobe (winc & ~full), combinational
//   waddr        RAM write address (low bits of binary write pointer)
//   wptr         registered Gray write pointer toward the read domain
//   full         registered full flag
//   almost_full  registered almost-full flag (level >= DEPTH - af_margin)
//   wlevel       registered occupancy, 0..DEPTH, pessimistic
//   overflow     sticky flag: write requested while full
// -----------------------------------------------------------------------------
module wptr_full_level
    import afifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    input  logic [ADDR_WIDTH-1:0] af_margin,
    input  logic                  ovf_clr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  overflow
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (ADDR_WIDTH < ADDR_WIDTH_MIN || ADDR_WIDTH > ADDR_WIDTH_MAX) begin : g_bad_addr_width
        $error("wptr_full_level: ADDR_WIDTH out of legal range");
    end

    logic [PTR_W-1:0] wbin_q,  wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q,  full_d;
    logic             af_q,    af_d;
    logic             ovf_q,   ovf_d;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rgray_full;
    logic [PTR_W-1:0] af_thresh;
    logic             push;

    gray2bin #(
        .W (PTR_W)
    ) u_rptr_g2b (
        .gray_i (rptr_sync),
        .bin_o  (rbin)
    );

    // Full when the write pointer is one lap ahead: Gray compare with the
    // two MSBs of the read pointer inverted.
    assign rgray_full = {~rptr_sync[PTR_W-1:PTR_W-2], rptr_sync[PTR_W-3:0]};
    assign af_thresh  = PTR_W'(DEPTH) - PTR_W'(af_margin);

    always_comb begin
        push    = winc & ~full_q;
        wbin_d  = wbin_q + PTR_W'(push);
        wgray_d = PTR_W'(bin2gray(ptr_max_t'(wbin_d)));
        // Modular difference stays correct across the pointer MSB wrap.
        level_d = wbin_d - rbin;
        full_d  = (wgray_d == rgray_full);
        af_d    = (level_d >= af_thresh);
        // A new overflow in the same cycle as a clear takes priority.
        ovf_d   = (ovf_q & ~ovf_clr) | (winc & full_q);
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_en       = push;
    assign waddr       = wbin_q[ADDR_WIDTH-1:0];
    assign wptr        = wgray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wlevel      = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
module tb_wptr_full_level;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 8;

    logic          wclk = 1'b0;
    logic          rst  = 1'b1;
    logic          winc = 1'b0;
    logic [PW-1:0] rptr_sync = '0;
    logic [AW-1:0] af_margin = '0;
    logic          ovf_clr = 1'b0;
    logic          wr_en;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wlevel;
    logic          overflow;

    int n_chk  = 0;
    int n_fail = 0;

    wptr_full_level #(
        .ADDR_WIDTH (AW)
    ) dut (
        .wclk        (wclk),
        .rst         (rst),
        .winc        (winc),
        .rptr_sync   (rptr_sync),
        .af_margin   (af_margin),
        .ovf_clr     (ovf_clr),
        .wr_en       (wr_en),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Gray code of a count taken modulo the 16-value pointer space.
    function automatic int gray4(input int v);
        int b;
        b = v % 16;
        return b ^ (b >> 1);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"},  int'(wr_en), 0);
        chk({tag, "_waddr"},  int'(waddr), 0);
        chk({tag, "_wptr"},   int'(wptr), 0);
        chk({tag, "_full"},   int'(full), 0);
        chk({tag, "_af"},     int'(almost_full), 0);
        chk({tag, "_wlevel"}, int'(wlevel), 0);
        chk({tag, "_ovf"},    int'(overflow), 0);
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        winc = 1'b0; ovf_clr = 1'b0; rptr_sync = '0;
        rst = 1'b1;
        @(posedge wclk);
        @(posedge wclk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        bit winc;
        int rsync;
        bit clr;
        bit e_wr_en;
        int e_waddr;
        int e_level;
        bit e_full;
        bit e_af;
        bit e_ovf;
        int e_wptr;
    } vec_t;

    vec_t tbl[16];

    // Behavioural model state: counts of writes accepted and reads observed.
    int  m_w;
    bit  m_full;
    bit  m_ovf;
    int  rtrue;
    int  hist[$];

    task automatic run_random(input int margin, input int seg);
        int budget;
        int rsync;
        bit wi, cl, ew;
        int lvl;
        do_reset();
        af_margin = AW'(margin);
        m_w = 0; m_full = 0; m_ovf = 0; rtrue = 0;
        hist.delete();
        hist.push_back(0);
        budget = 0;
        while (m_w < 40 && budget < 2000) begin
            budget++;
            if (rtrue < m_w && $urandom_range(0, 2) != 0) rtrue++;
            hist.push_back(rtrue);
            if (hist.size() > 3) void'(hist.pop_front());
            rsync = hist[0];
            wi = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 7) == 0);
            winc = wi; ovf_clr = cl; rptr_sync = PW'(gray4(rsync));
            #1;
            ew = wi && !m_full;
            chk("rnd_wr_en", int'(wr_en), int'(ew));
            chk("rnd_waddr", int'(waddr), m_w % DEPTH);
            @(posedge wclk);
            m_ovf = (m_ovf && !cl) || (wi && m_full);
            if (ew) m_w++;
            lvl    = m_w - rsync;
            m_full = (lvl == DEPTH);
            #1;
            chk("rnd_wlevel", int'(wlevel), lvl);
            chk("rnd_full", int'(full), int'(m_full));
            chk("rnd_af", int'(almost_full), int'(lvl >= DEPTH - margin));
            chk("rnd_ovf", int'(overflow), int'(m_ovf));
            chk("rnd_wptr", int'(wptr), gray4(m_w));
            chk("rnd_full_eq_level", int'(full), int'(wlevel == PW'(DEPTH)));
            chk("rnd_level_ge_true", int'(int'(wlevel) >= m_w - rtrue), 1);
            chk("rnd_level_le_depth", int'(int'(wlevel) <= DEPTH), 1);
        end
        chk("rnd_budget_seg", int'(m_w >= 40), 1);
        if (m_w < 40) $display("FAIL rnd_budget: segment %0d only %0d writes", seg, m_w);
        winc = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        int g8[8] = '{1, 3, 2, 6, 7, 5, 4, 12};

        // Reset state
        #2;
        check_all_zero("reset");

        // Directed table: fill, overflow, clear priority, release, refill.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1, 0, 0, 1, i, i + 1, (i == 7), (i >= 5), 0, g8[i]};
        tbl[8]  = '{1, 0, 0, 0, 0, 8, 1, 1, 1, 12};
        tbl[9]  = '{1, 0, 0, 0, 0, 8, 1, 1, 1, 12};
        tbl[10] = '{0, 0, 1, 0, 0, 8, 1, 1, 0, 12};
        tbl[11] = '{1, 0, 0, 0, 0, 8, 1, 1, 1, 12};
        tbl[12] = '{1, 0, 1, 0, 0, 8, 1, 1, 1, 12};
        tbl[13] = '{0, 0, 1, 0, 0, 8, 1, 1, 0, 12};
        tbl[14] = '{0, 1, 0, 0, 0, 7, 0, 1, 0, 12};
        tbl[15] = '{1, 1, 0, 1, 0, 8, 1, 1, 0, 13};

        do_reset();
        af_margin = AW'(2);
        for (int i = 0; i < 16; i++) begin
            winc = tbl[i].winc; ovf_clr = tbl[i].clr;
            rptr_sync = PW'(gray4(tbl[i].rsync));
            #1;
            chk($sformatf("tbl%0d_wr_en", i), int'(wr_en), int'(tbl[i].e_wr_en));
            chk($sformatf("tbl%0d_waddr", i), int'(waddr), tbl[i].e_waddr);
            @(posedge wclk);
            #1;
            chk($sformatf("tbl%0d_wlevel", i), int'(wlevel), tbl[i].e_level);
            chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].e_full));
            chk($sformatf("tbl%0d_af", i), int'(almost_full), int'(tbl[i].e_af));
            chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_wptr", i), int'(wptr), tbl[i].e_wptr);
            chk($sformatf("tbl%0d_full_eq_level", i), int'(full), int'(wlevel == PW'(DEPTH)));
        end
        winc = 1'b0; ovf_clr = 1'b0;

        // Asynchronous reset mid-burst at level 5.
        do_reset();
        af_margin = '0;
        winc = 1'b1;
        repeat (5) @(posedge wclk);
        #1 winc = 1'b0;
        chk("rstmid_level5", int'(wlevel), 5);
        chk("rstmid_waddr5", int'(waddr), 5);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rstmid");
        @(posedge wclk);
        #1 rst = 1'b0;
        winc = 1'b1;
        #1;
        chk("rstpost_wr_en", int'(wr_en), 1);
        chk("rstpost_waddr", int'(waddr), 0);
        @(posedge wclk);
        #1 winc = 1'b0;
        chk("rstpost_wlevel", int'(wlevel), 1);
        chk("rstpost_wptr", int'(wptr), 1);

        // Randomized wrap-around against the count-based model.
        run_random(0, 0);
        run_random(3, 1);
        run_random(int'($urandom_range(0, 7)), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wptr_full_level.md
# wptr_full_level

Write-side pointer and status generator for the asynchronous FIFO, operating in the write clock domain. It replaces the plain write-pointer/full block with a parametrised version that adds:

- an occupancy level output,
- a programmable almost-full flag,
- a memory write strobe,
- a sticky overflow error.

It consumes the read pointer after its two-flop synchroniser and drives the Gray write pointer toward the read-side synchroniser and the binary write address into the dual-port RAM.

## Interface
Parameters:
- ADDR_WIDTH, default 3: RAM address bits, legal 2..10. DEPTH = 2**ADDR_WIDTH.

Ports:
- wclk  in  1  write-domain clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- winc  in  1  write request for the current cycle
- rptr_sync  in  ADDR_WIDTH+1  Gray read pointer, already synchronised to wclk
- af_margin  in  ADDR_WIDTH  almost-full margin; quasi-static, change only while idle
- ovf_clr  in  1  clears the overflow flag
- wr_en  out  1  RAM write strobe, combinational: winc & ~full
- waddr  out  ADDR_WIDTH  RAM write address, equal to wbin[ADDR_WIDTH-1:0]
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer
- full  out  1  registered full flag
- almost_full  out  1  registered almost-full flag
- wlevel  out  ADDR_WIDTH+1  registered occupancy, range 0..DEPTH
- overflow  out  1  sticky error flag

## Operation
Reset value of every output and register is 0, so the block comes out of reset empty and not full.

Write pointer:
- Internal binary pointer wbin is ADDR_WIDTH+1 bits and wraps modulo 2**(ADDR_WIDTH+1).
- push = winc & ~full.
- wbin_next = wbin + push.
- wgray_next = wbin_next ^ (wbin_next >> 1).

Per-cycle register updates:
- wbin <= wbin_next; wptr <= wgray_next.
- rbin = gray-to-binary of rptr_sync (combinational).
- level_next = wbin_next − rbin, modulo 2**(ADDR_WIDTH+1).
- wlevel <= level_next.
- full <= (wgray_next == {~rptr_sync[MSB:MSB-1], rptr_sync[MSB-2:0]}). This must equal (level_next == DEPTH), and the bench asserts that equivalence.
- almost_full <= (level_next >= DEPTH − af_margin). With af_margin = 0, almost_full equals full.
- overflow <= (overflow & ~ovf_clr) | (winc & full). If a clear and a new overflow occur in the same cycle, the set wins.

Blocking and level semantics:
- A write request while full is dropped. wbin, waddr, wptr and the RAM are all unchanged.
- wlevel is pessimistic, because rptr_sync lags the true read pointer. It never under-reports occupancy, and so never permits overflow of the RAM.

## Timing
- wr_en and waddr are valid in the same cycle as winc; the RAM writes on that edge.
- wptr, full, almost_full and wlevel reflect a push one wclk edge after it (zero added latency versus the write).
- Full assertion: the write that fills the last slot raises full on the same edge it is accepted. The next winc is blocked.
- Full release: full deasserts on the first edge after rptr_sync advances, which is 2 wclk plus the read-domain delay after the actual read.
- Simultaneous push and read-pointer advance: level_next accounts for both in one cycle, so full may stay 0 with the level unchanged.
- Wrap-around: pointer wrap is seamless; wlevel stays correct across the MSB toggle.
- Reset mid-operation: rst forces all state to 0 asynchronously. Reset must be applied to both FIFO domains together; this block does not detect a one-sided reset.

## Structure
- Shared package `afifo_pkg` holds:
  - the bin2gray function,
  - the gray2bin function,
  - the ADDR_WIDTH legality range constants.
- One sub-module, `gray2bin`: parametrised width, purely combinational XOR prefix chain, instantiated for rptr_sync. The read-side counterpart will reuse it.
- Everything else is flat in `wptr_full_level`.

## Test plan
All scenarios use ADDR_WIDTH=3 (DEPTH=8).
- Fill: rptr_sync=0, winc held 8 cycles.
  - wlevel steps 1..8; full=1 after the 8th edge.
  - wptr = 4'b1100; waddr returns to 0.
- Overflow: from full, winc for 2 cycles.
  - wr_en=0; wptr unchanged; overflow=1 and stays 1.
  - ovf_clr pulse → 0. ovf_clr coincident with another blocked winc → overflow stays 1.
- Almost-full: af_margin=2, write from empty.
  - almost_full rises on the edge where wlevel becomes 6; full stays 0 until 8.
- Release: from full, drive rptr_sync=4'b0001 (gray of 1).
  - full=0 and wlevel=7 next edge; one winc → full=1 again.
- Wrap: 40 writes with a model reader driving delayed Gray rptr_sync.
  - wlevel never below the true count and never above 8; no dropped accepted write; waddr sequence continuous mod 8.
- Reset: assert rst asynchronously mid-burst at wlevel=5.
  - All outputs 0 immediately, without waiting for a clock edge; first write after release uses waddr=0.
